// File: rtl/exu_shift_arbiter_ysyx23060136.sv
// exu_shift_arbiter_ysyx23060136: two-port arbitrated barrel shifter with a registered result; define EXU_SHIFT_ARB_RR_EN for round-robin tie-break (fixed port-0 priority otherwise)
module exu_shift_arbiter_ysyx23060136 #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_din,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req0_lr,
    input  logic               req0_al,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_din,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic               req1_lr,
    input  logic               req1_al,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp_dout,
    output logic               busy
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, next_state;
    logic out_vld, out_id, last_gnt;
    logic [DATA_W-1:0] out_data, din, res;
    logic signed [DATA_W-1:0] sra;
    logic [SHAMT_W-1:0] shamt;
    logic rr_pick, gnt, drain, can_accept, accept, lr, al;
    assign out_vld    = (state == FULL);
    assign rsp0_valid = out_vld & ~out_id;
    assign rsp1_valid = out_vld & out_id;
    assign rsp_dout   = out_data;
    assign busy       = out_vld;
    // grant, handshake, shared shifter and next state
    always_comb begin
`ifdef EXU_SHIFT_ARB_RR_EN
        rr_pick    = ~last_gnt;
`else
        rr_pick    = 1'b0 & last_gnt;
`endif
        gnt        = req1_valid & (~req0_valid | rr_pick);
        drain      = out_vld & (out_id ? rsp1_ready : rsp0_ready);
        can_accept = ~out_vld | drain;
        req0_ready = can_accept & ~gnt;
        req1_ready = can_accept & gnt;
        accept     = gnt ? req1_valid & req1_ready : req0_valid & req0_ready;
        din        = gnt ? req1_din : req0_din;
        shamt      = gnt ? req1_shamt : req0_shamt;
        lr         = gnt ? req1_lr : req0_lr;
        al         = gnt ? req1_al : req0_al;
        sra        = $signed(din) >>> shamt;
        res        = lr ? din << shamt : al ? sra : din >> shamt;
        next_state = accept ? FULL : drain ? EMPTY : state;
    end
    // result-slot occupancy
    always_ff @(posedge clk) begin
        state <= rst ? EMPTY : next_state;
    end
    // latch result, owner and last grant on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_id   <= 1'b0;
            last_gnt <= 1'b1;
        end else if (accept) begin
            out_data <= res;
            out_id   <= gnt;
            last_gnt <= gnt;
        end
    end
endmodule

// File: tb/tb_exu_shift_arbiter_ysyx23060136.sv
// tb_exu_shift_arbiter_ysyx23060136: directed and randomized checks against a behavioural model
module tb_exu_shift_arbiter_ysyx23060136;
`ifdef EXU_SHIFT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req0_valid = 0, req0_ready, req0_lr = 0, req0_al = 0;
    logic req1_valid = 0, req1_ready, req1_lr = 0, req1_al = 0;
    logic [31:0] req0_din = 0, req1_din = 0, rsp_dout;
    logic [4:0] req0_shamt = 0, req1_shamt = 0;
    logic rsp0_valid, rsp0_ready = 0, rsp1_valid, rsp1_ready = 0, busy;
    int checks = 0, failures = 0;
    logic m_vld, m_id, m_last, acc0, acc1;
    logic [31:0] m_data;

    exu_shift_arbiter_ysyx23060136 dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
        .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
        .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_dout(rsp_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shf(input logic [31:0] d, input logic [4:0] s, input logic l, input logic a);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            int j;
            j = l ? i - int'(s) : i + int'(s);
            r[i] = (j >= 0 && j < 32) ? d[j] : (!l && a ? d[31] : 1'b0);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_last = 1; m_data = 0;
    endtask

    task automatic step();
        logic g, can, acc, e0, e1;
        @(negedge clk);
        can = !m_vld || (m_id ? rsp1_ready : rsp0_ready);
        g = (req0_valid && req1_valid) ? (RR ? !m_last : 1'b0) : req1_valid;
        e0 = can && !g;
        e1 = can && g;
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_vld && !m_id});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_vld && m_id});
        chk("busy", {31'b0, busy}, {31'b0, m_vld});
        chk("rsp_dout", rsp_dout, m_data);
        acc = g ? (req1_valid && e1) : (req0_valid && e0);
        @(posedge clk);
        acc0 = 0; acc1 = 0;
        if (rst) model_reset();
        else if (acc) begin
            m_data = g ? shf(req1_din, req1_shamt, req1_lr, req1_al) : shf(req0_din, req0_shamt, req0_lr, req0_al);
            m_id = g; m_vld = 1; m_last = g;
            acc0 = !g; acc1 = g;
        end else if (m_vld && (m_id ? rsp1_ready : rsp0_ready)) m_vld = 0;
        #1;
    endtask

    logic [31:0] sd [4] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h0F0F0000};
    logic [4:0]  ss [4] = '{5'd31, 5'd4, 5'd31, 5'd8};
    logic        sl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        sa [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] se [4] = '{32'h80000000, 32'hF8000000, 32'h00000001, 32'h0F000000};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        #1;
        chk("reset_dout", rsp_dout, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        // tie straight after reset: port 0 first, then per policy
        req0_valid = 1; req0_din = 32'h1; req0_shamt = 4; req0_lr = 1;
        req1_valid = 1; req1_din = 32'h100; req1_shamt = 8; req1_lr = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("tie_gnt0", {31'b0, req0_ready}, {31'b0, RR ? (t % 2 == 0) : 1'b1});
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();
        // single port-0 ops
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1; req0_din = sd[k]; req0_shamt = ss[k]; req0_lr = sl[k]; req0_al = sa[k];
            step();
            req0_valid = 0;
            #1;
            chk("single_valid", {31'b0, rsp0_valid}, 32'h1);
            chk("single_dout", rsp_dout, se[k]);
        end
        step();
        // back-pressure on port 1
        req1_valid = 1; req1_din = 32'hFFFF0000; req1_shamt = 16; req1_lr = 0; req1_al = 1;
        rsp1_ready = 0;
        step();
        req1_valid = 0;
        req0_valid = 1; req0_din = 32'h3; req0_shamt = 1; req0_lr = 1; req0_al = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_dout", rsp_dout, 32'hFFFFFFFF);
            chk("stall_rsp1", {31'b0, rsp1_valid}, 32'h1);
            chk("stall_req0", {31'b0, req0_ready}, 32'h0);
            step();
        end
        rsp1_ready = 1;
        #1;
        chk("release_req0", {31'b0, req0_ready}, 32'h1);
        step();
        req0_valid = 0;
        #1;
        chk("release_rsp0", {31'b0, rsp0_valid}, 32'h1);
        chk("release_dout", rsp_dout, 32'h6);
        // drain and accept in one cycle
        req1_valid = 1; req1_din = 32'h80000000; req1_shamt = 1; req1_lr = 0; req1_al = 1;
        #1;
        chk("b2b_req1", {31'b0, req1_ready}, 32'h1);
        step();
        req1_valid = 0;
        #1;
        chk("b2b_rsp1", {31'b0, rsp1_valid}, 32'h1);
        chk("b2b_dout", rsp_dout, 32'hC0000000);
        step();
        // reset while full and stalled
        req0_valid = 1; req0_din = 32'h5; req0_shamt = 0; req0_lr = 1; rsp0_ready = 0;
        step();
        req0_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_rsp0", {31'b0, rsp0_valid}, 32'h0);
        chk("rst_rsp1", {31'b0, rsp1_valid}, 32'h0);
        chk("rst_dout", rsp_dout, 32'h0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_tie0", {31'b0, req0_ready}, 32'h1);
        chk("rst_tie1", {31'b0, req1_ready}, 32'h0);
        step();
        // randomized traffic honouring the hold-until-accepted contract
        for (int n = 0; n < 400; n++) begin
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(0, 1); req0_din = $urandom; req0_shamt = 5'($urandom);
                req0_lr = 1'($urandom); req0_al = 1'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(0, 1); req1_din = $urandom; req1_shamt = 5'($urandom);
                req1_lr = 1'($urandom); req1_al = 1'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
